// File: rtl/minbd_eject_pkg.sv
// Ejection helpers: first-K-of-N priority grant and statistics counter width.
package minbd_eject_pkg;

  localparam int MAX_CHNL   = 32;
  localparam int STAT_CNT_W = 32;

  // Grant the lowest-indexed requesters, at most k of them.
  function automatic logic [MAX_CHNL-1:0] first_k_of_n(input logic [MAX_CHNL-1:0] req,
                                                        input int unsigned         k);
    logic [MAX_CHNL-1:0] gnt;
    int unsigned         cnt;
    gnt = '0;
    cnt = 0;
    for (int i = 0; i < MAX_CHNL; i++) begin
      if (req[i] && (cnt < k)) begin
        gnt[i] = 1'b1;
        cnt    = cnt + 1;
      end
    end
    return gnt;
  endfunction

  function automatic logic [STAT_CNT_W-1:0] sat_add(input logic [STAT_CNT_W-1:0] a,
                                                     input logic [STAT_CNT_W-1:0] b);
    logic [STAT_CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[STAT_CNT_W] ? '1 : sum[STAT_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/minbd_flit_pkg.sv
// Shared flit header: internal flit format carried on every router channel.
package minbd_flit_pkg;

  localparam int WIDTH_FLIT_INT = 32;

  typedef struct packed {
    logic [3:0]  dst;
    logic [3:0]  src;
    logic [15:0] seq;
    logic [7:0]  payload;
  } flit_int_t;

endpackage

// File: rtl/multi_wr_fifo.sv
// Flit FIFO with WR_PORTS contiguous write ports (port 0 first) and one read port.
// Writes land on the clock edge; rd_dat is the registered head (zero when empty); rd_en while empty is ignored.
module multi_wr_fifo
  import minbd_flit_pkg::*;
#(
  parameter  int DEPTH    = 4,
  parameter  int WR_PORTS = 2,
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OW       = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WR_PORTS-1:0]     wr_en,
  input  flit_int_t [WR_PORTS-1:0] wr_dat,
  input  logic                    rd_en,
  output flit_int_t               rd_dat,
  output logic [OW-1:0]           occupancy
);

  flit_int_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [OW-1:0]   wr_cnt;
  logic            pop;

  always_comb begin
    wr_cnt = '0;
    for (int j = 0; j < WR_PORTS; j++) begin
      wr_cnt = wr_cnt + OW'(wr_en[j]);
    end
  end

  assign pop    = rd_en && (occupancy != '0);
  assign rd_dat = (occupancy != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      wr_ptr    <= AW'((int'(wr_ptr) + int'(wr_cnt)) % DEPTH);
      if (pop) begin
        rd_ptr <= AW'((int'(rd_ptr) + 1) % DEPTH);
      end
      occupancy <= occupancy + wr_cnt - OW'(pop);
    end
  end

  // Storage is not cleared on reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < WR_PORTS; j++) begin
        if (wr_en[j]) begin
          mem[AW'((int'(wr_ptr) + j) % DEPTH)] <= wr_dat[j];
        end
      end
    end
  end

endmodule

// File: rtl/flit_eject_buffer.sv
// Removes up to EJECT_WIDTH requested flits per cycle into a local buffer; grants are combinational, out_flit lags one cycle.
// Backpressure: out_ready pops the head; a full buffer or the width cap denies requests (flit deflects). EJECT_STATS_EN adds counters.
module flit_eject_buffer
  import minbd_flit_pkg::*;
  import minbd_eject_pkg::*;
#(
  parameter int NUM_CHNL    = 4,
  parameter int EJECT_WIDTH = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  flit_int_t [NUM_CHNL-1:0]      din,
  input  logic [NUM_CHNL-1:0]           eject_req,
  output flit_int_t [NUM_CHNL-1:0]      dout,
  output logic [NUM_CHNL-1:0]           eject_gnt,
  output flit_int_t                     out_flit,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
`ifdef EJECT_STATS_EN
  ,
  output logic [STAT_CNT_W-1:0]         eject_cnt,
  output logic [STAT_CNT_W-1:0]         eject_deny_cnt
`endif
);

  int unsigned                free_slots;
  int unsigned                grant_lim;
  logic [MAX_CHNL-1:0]        gnt_full;
  logic                       unused_gnt_bits;
  logic [EJECT_WIDTH-1:0]     wr_en;
  flit_int_t [EJECT_WIDTH-1:0] wr_dat;

  // Free space is taken at cycle start; a same-cycle pop does not widen it.
  always_comb begin
    free_slots = 32'(FIFO_DEPTH) - 32'(occupancy);
    grant_lim  = (free_slots < 32'(EJECT_WIDTH)) ? free_slots : 32'(EJECT_WIDTH);
    gnt_full   = reset ? '0 : first_k_of_n(MAX_CHNL'(eject_req), grant_lim);
  end

  assign eject_gnt       = gnt_full[NUM_CHNL-1:0];
  assign unused_gnt_bits = ^gnt_full;

  always_comb begin
    for (int i = 0; i < NUM_CHNL; i++) begin
      dout[i] = eject_gnt[i] ? '0 : din[i];
    end
  end

  // Pack granted flits onto write ports in ascending channel order.
  always_comb begin
    int slot;
    wr_en  = '0;
    wr_dat = '0;
    slot   = 0;
    for (int i = 0; i < NUM_CHNL; i++) begin
      if (eject_gnt[i] && (slot < EJECT_WIDTH)) begin
        wr_en[slot]  = 1'b1;
        wr_dat[slot] = din[i];
        slot         = slot + 1;
      end
    end
  end

  multi_wr_fifo #(
    .DEPTH    (FIFO_DEPTH),
    .WR_PORTS (EJECT_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_dat    (wr_dat),
    .rd_en     (out_ready),
    .rd_dat    (out_flit),
    .occupancy (occupancy)
  );

  assign out_valid = (occupancy != '0);

`ifdef EJECT_STATS_EN
  logic [STAT_CNT_W-1:0] n_gnt;
  logic [STAT_CNT_W-1:0] n_deny;

  assign n_gnt  = STAT_CNT_W'($countones(eject_gnt));
  assign n_deny = STAT_CNT_W'($countones(eject_req)) - n_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      eject_cnt      <= '0;
      eject_deny_cnt <= '0;
    end else begin
      eject_cnt      <= sat_add(eject_cnt, n_gnt);
      eject_deny_cnt <= sat_add(eject_deny_cnt, n_deny);
    end
  end
`endif

endmodule
